// File: rtl/order_tx_serializer_if.sv
// Quote-output link between the trading core, the serializer and the NIC side.
// Carries the bundle-pair capture port and the valid/ready beat stream.
interface order_tx_serializer_if #(
  parameter int REG_WIDTH = 32
);
  logic                 i_valid;
  logic [REG_WIDTH-1:0] i_reg_0_b, i_reg_1_b, i_reg_2_b, i_reg_3_b, i_reg_4_b,
                        i_reg_5_b, i_reg_6_b, i_reg_7_b, i_reg_8_b;
  logic [REG_WIDTH-1:0] i_reg_0_s, i_reg_1_s, i_reg_2_s, i_reg_3_s, i_reg_4_s,
                        i_reg_5_s, i_reg_6_s, i_reg_7_s, i_reg_8_s;
  logic                 i_tx_ready;
  logic [REG_WIDTH-1:0] o_tx_data;
  logic                 o_tx_valid;
  logic                 o_tx_sof;
  logic                 o_tx_eof;
  logic                 o_tx_side;
  logic                 o_full;
  logic [15:0]          o_drop_count;

  // Core / downstream side: drives bundles and ready, observes the stream.
  modport master (
    output i_valid,
    output i_reg_0_b, i_reg_1_b, i_reg_2_b, i_reg_3_b, i_reg_4_b,
           i_reg_5_b, i_reg_6_b, i_reg_7_b, i_reg_8_b,
    output i_reg_0_s, i_reg_1_s, i_reg_2_s, i_reg_3_s, i_reg_4_s,
           i_reg_5_s, i_reg_6_s, i_reg_7_s, i_reg_8_s,
    output i_tx_ready,
    input  o_tx_data, o_tx_valid, o_tx_sof, o_tx_eof, o_tx_side,
    input  o_full, o_drop_count
  );

  // Serializer side.
  modport slave (
    input  i_valid,
    input  i_reg_0_b, i_reg_1_b, i_reg_2_b, i_reg_3_b, i_reg_4_b,
           i_reg_5_b, i_reg_6_b, i_reg_7_b, i_reg_8_b,
    input  i_reg_0_s, i_reg_1_s, i_reg_2_s, i_reg_3_s, i_reg_4_s,
           i_reg_5_s, i_reg_6_s, i_reg_7_s, i_reg_8_s,
    input  i_tx_ready,
    output o_tx_data, o_tx_valid, o_tx_sof, o_tx_eof, o_tx_side,
    output o_full, o_drop_count
  );
endinterface

// File: rtl/order_tx_serializer.sv
// Transmit serializer: buffers DEPTH buy/sell bundle pairs and streams them as
// REG_WIDTH-bit beats, buy message first, then sell.
// Optional feature macro ORDER_TX_CHECKSUM_EN appends an XOR word (word 9)
// to every message.
module order_tx_serializer #(
  parameter int REG_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input logic              i_clk,
  input logic              i_reset_n,
  order_tx_serializer_if.slave bus
);
`ifdef ORDER_TX_CHECKSUM_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd8;
`endif
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_BUY, SEND_SELL} state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [PW-1:0]        wr_ptr, rd_ptr, rd_ptr_d;
  logic [OW-1:0]        occ, occ_left, occ_d;
  logic [15:0]          drop_cnt;
  logic                 xfer, push, pop, last, bypass;
  logic [4:0]           word_sel;
  logic [17:0][REG_WIDTH-1:0] in_words;
  logic [REG_WIDTH-1:0] mem [DEPTH][18];
  logic [REG_WIDTH-1:0] data_q, data_d, rd_word;
  logic                 valid_q, sof_q, eof_q, side_q;
  logic                 valid_d, sof_d, eof_d, side_d;
`ifdef ORDER_TX_CHECKSUM_EN
  logic [REG_WIDTH-1:0] csum;
`endif

  // Slot layout: words 0..8 buy, 9..17 sell.
  assign in_words = {bus.i_reg_8_s, bus.i_reg_7_s, bus.i_reg_6_s, bus.i_reg_5_s,
                     bus.i_reg_4_s, bus.i_reg_3_s, bus.i_reg_2_s, bus.i_reg_1_s,
                     bus.i_reg_0_s,
                     bus.i_reg_8_b, bus.i_reg_7_b, bus.i_reg_6_b, bus.i_reg_5_b,
                     bus.i_reg_4_b, bus.i_reg_3_b, bus.i_reg_2_b, bus.i_reg_1_b,
                     bus.i_reg_0_b};

  // Next-state and next registered beat. The output register is loaded with
  // the beat that will be on the wire after this edge, so a capture into an
  // empty FIFO bypasses buy word 0 straight from the inputs.
  always_comb begin
    xfer     = valid_q && bus.i_tx_ready;
    push     = bus.i_valid && (occ != FULL_OCC);
    last     = (idx_q == LAST);
    pop      = xfer && (state_q == SEND_SELL) && last;
    occ_left = occ - OW'(pop);
    occ_d    = occ_left + OW'(push);
    rd_ptr_d = rd_ptr + PW'(pop);
    bypass   = (occ_left == '0);
    state_d  = state_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: if (occ != '0 || push) begin
        state_d = SEND_BUY;
        idx_d   = 4'd0;
      end
      SEND_BUY: if (xfer) begin
        if (last) begin
          state_d = SEND_SELL;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      SEND_SELL: if (xfer) begin
        if (last) begin
          state_d = (occ_d != '0) ? SEND_BUY : IDLE;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase

    valid_d  = (state_d != IDLE);
    side_d   = (state_d == SEND_SELL);
    sof_d    = valid_d && (idx_d == 4'd0);
    eof_d    = valid_d && (idx_d == LAST);
    word_sel = (side_d ? 5'd9 : 5'd0) + {1'b0, (idx_d > 4'd8) ? 4'd8 : idx_d};
    rd_word  = mem[rd_ptr_d][word_sel];
`ifdef ORDER_TX_CHECKSUM_EN
    csum = '0;
    for (int k = 0; k < 9; k++)
      csum = csum ^ mem[rd_ptr_d][(side_d ? 5'd9 : 5'd0) + 5'(k)];
    if (idx_d == 4'd9) rd_word = csum;
`endif
    if (!valid_d)    data_d = '0;
    else if (bypass) data_d = in_words[0];
    else             data_d = rd_word;
  end

  // FSM state, beat index and registered beat outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      side_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      side_q  <= side_d;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      drop_cnt <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_d;
      occ    <= occ_d;
      if (bus.i_valid && !push && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Bundle storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (push)
      for (int k = 0; k < 18; k++) mem[wr_ptr][k] <= in_words[k];
  end

  assign bus.o_tx_data    = data_q;
  assign bus.o_tx_valid   = valid_q;
  assign bus.o_tx_sof     = sof_q;
  assign bus.o_tx_eof     = eof_q;
  assign bus.o_tx_side    = side_q;
  assign bus.o_full       = (occ == FULL_OCC);
  assign bus.o_drop_count = drop_cnt;
endmodule

// File: tb/tb_order_tx_serializer.sv
// Directed bench for order_tx_serializer: single pair, backpressure, overflow,
// back-to-back pairs, mid-message reset and (with ORDER_TX_CHECKSUM_EN) checksum.
module tb_order_tx_serializer;
  localparam int RW = 32;
`ifdef ORDER_TX_CHECKSUM_EN
  localparam int NW = 10;
`else
  localparam int NW = 9;
`endif

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;

  order_tx_serializer_if #(.REG_WIDTH(RW)) bus ();
  order_tx_serializer #(.REG_WIDTH(RW), .DEPTH(2)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    logic        side;
  } beat_t;

  beat_t exp_q[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic set_pair(input logic [31:0] bb, input logic [31:0] sb);
    bus.i_reg_0_b = bb;       bus.i_reg_1_b = bb + 32'd1; bus.i_reg_2_b = bb + 32'd2;
    bus.i_reg_3_b = bb + 32'd3; bus.i_reg_4_b = bb + 32'd4; bus.i_reg_5_b = bb + 32'd5;
    bus.i_reg_6_b = bb + 32'd6; bus.i_reg_7_b = bb + 32'd7; bus.i_reg_8_b = bb + 32'd8;
    bus.i_reg_0_s = sb;       bus.i_reg_1_s = sb + 32'd1; bus.i_reg_2_s = sb + 32'd2;
    bus.i_reg_3_s = sb + 32'd3; bus.i_reg_4_s = sb + 32'd4; bus.i_reg_5_s = sb + 32'd5;
    bus.i_reg_6_s = sb + 32'd6; bus.i_reg_7_s = sb + 32'd7; bus.i_reg_8_s = sb + 32'd8;
  endtask

  // Expected beats for one pair whose word k is base + k.
  task automatic push_pair(input logic [31:0] bb, input logic [31:0] sb);
    beat_t b;
    logic [31:0] base, x;
    for (int s = 0; s < 2; s++) begin
      base = (s == 1) ? sb : bb;
      x = 32'd0;
      for (int k = 0; k < 9; k++) begin
        b.data = base + 32'(k);
        b.sof  = (k == 0);
        b.eof  = (k == NW - 1);
        b.side = (s == 1);
        exp_q.push_back(b);
        x = x ^ b.data;
      end
      if (NW == 10) begin
        b.data = x; b.sof = 1'b0; b.eof = 1'b1; b.side = (s == 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Consume exp_q from the stream. mode 0: ready always 1; mode 1: ready
  // alternates 1/0. Optionally injects a second pair after inject_at transfers.
  task automatic drain(input int mode, input bit cont, input int inject_at,
                       input logic [31:0] ib, input logic [31:0] isb, input int budget);
    int cyc = 0;
    int got = 0;
    bit hold_pend = 1'b0;
    bit injected = 1'b0;
    logic [35:0] held = '0;
    beat_t cur, b;
    while (exp_q.size() > 0 && cyc < budget) begin
      cur.data = bus.o_tx_data; cur.sof = bus.o_tx_sof;
      cur.eof  = bus.o_tx_eof;  cur.side = bus.o_tx_side;
      if (hold_pend) check("stall_hold", {bus.o_tx_valid, cur}, held);
      if (cont) check("continuous_valid", bus.o_tx_valid, 1);
      bus.i_valid = 1'b0;
      if (!injected && got == inject_at) begin
        set_pair(ib, isb);
        bus.i_valid = 1'b1;
        push_pair(ib, isb);
        injected = 1'b1;
      end
      bus.i_tx_ready = (mode == 0) || (cyc % 2 == 0);
      hold_pend = bus.o_tx_valid && !bus.i_tx_ready;
      held = {bus.o_tx_valid, cur};
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        b = exp_q.pop_front();
        check($sformatf("beat%0d", got), cur, b);
        got++;
      end
      step();
      cyc++;
    end
    bus.i_valid = 1'b0;
    bus.i_tx_ready = 1'b1;
    check("drain_done_remaining", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int seen;
    bus.i_valid = 1'b0;
    bus.i_tx_ready = 1'b1;
    set_pair(32'd0, 32'd0);
    repeat (3) @(negedge i_clk);

    // Reset state
    check("rst_data",  bus.o_tx_data, 0);
    check("rst_valid", bus.o_tx_valid, 0);
    check("rst_sof",   bus.o_tx_sof, 0);
    check("rst_eof",   bus.o_tx_eof, 0);
    check("rst_side",  bus.o_tx_side, 0);
    check("rst_full",  bus.o_full, 0);
    check("rst_drop",  bus.o_drop_count, 0);
    i_reset_n = 1'b1;
    step();
    check("idle_valid", bus.o_tx_valid, 0);

    // Single pair, ready held high; inputs scrambled after capture
    set_pair(32'h100, 32'h200);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    set_pair(32'hDEAD0000, 32'hBEEF0000);
    check("latency_valid", bus.o_tx_valid, 1);
    check("latency_word0", bus.o_tx_data, 32'h100);
    push_pair(32'h100, 32'h200);
    drain(0, 1'b1, -1, 32'd0, 32'd0, 100);
    check("single_end_valid", bus.o_tx_valid, 0);

    // Backpressure: ready alternating
    set_pair(32'h100, 32'h200);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    push_pair(32'h100, 32'h200);
    drain(1, 1'b0, -1, 32'd0, 32'd0, 200);
    check("bp_no_extra", bus.o_tx_valid, 0);

    // Overflow: three pulses with ready low
    bus.i_tx_ready = 1'b0;
    set_pair(32'h100, 32'h200);
    bus.i_valid = 1'b1;
    step();
    set_pair(32'h300, 32'h400);
    step();
    bus.i_valid = 1'b0;
    check("ovf_full_after2", bus.o_full, 1);
    check("ovf_drop_after2", bus.o_drop_count, 0);
    set_pair(32'h500, 32'h600);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    check("ovf_full_after3", bus.o_full, 1);
    check("ovf_drop_after3", bus.o_drop_count, 1);
    push_pair(32'h100, 32'h200);
    push_pair(32'h300, 32'h400);
    drain(0, 1'b1, -1, 32'd0, 32'd0, 200);
    check("ovf_end_valid", bus.o_tx_valid, 0);
    check("ovf_end_full", bus.o_full, 0);
    check("ovf_drop_kept", bus.o_drop_count, 1);

    // Back-to-back: second pair captured during beat 5
    set_pair(32'h700, 32'h800);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    push_pair(32'h700, 32'h800);
    drain(0, 1'b1, 5, 32'h900, 32'hA00, 200);
    check("b2b_end_valid", bus.o_tx_valid, 0);

    // Reset mid-message after 5 beats
    set_pair(32'hB00, 32'hC00);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    repeat (5) step();
    check("mid_valid", bus.o_tx_valid, 1);
    check("mid_data", bus.o_tx_data, 32'hB05);
    i_reset_n = 1'b0;
    #1;
    check("mrst_data",  bus.o_tx_data, 0);
    check("mrst_valid", bus.o_tx_valid, 0);
    check("mrst_sof",   bus.o_tx_sof, 0);
    check("mrst_eof",   bus.o_tx_eof, 0);
    check("mrst_side",  bus.o_tx_side, 0);
    check("mrst_full",  bus.o_full, 0);
    check("mrst_drop",  bus.o_drop_count, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (bus.o_tx_valid) seen++;
    end
    check("post_reset_silent", seen, 0);

    // Fresh pair after reset
    set_pair(32'hD00, 32'hE00);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    push_pair(32'hD00, 32'hE00);
    drain(0, 1'b1, -1, 32'd0, 32'd0, 100);

`ifdef ORDER_TX_CHECKSUM_EN
    // Checksum: buy words 0x1..0x9 XOR to 0x1
    set_pair(32'h1, 32'h10);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    push_pair(32'h1, 32'h10);
    drain(0, 1'b1, -1, 32'd0, 32'd0, 100);
    check("csum_end_valid", bus.o_tx_valid, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/order_tx_serializer.md
# order_tx_serializer

Transmit-side serializer for the trading core's quote output. It captures one buy and one sell order bundle per `i_valid` pulse, each bundle being nine REG_WIDTH-bit words. It buffers up to DEPTH bundle pairs and streams them as 32-bit words over a valid/ready link: the buy message first, then the sell message. It sits directly downstream of the core's `o_reg_*_b` / `o_reg_*_s` / `o_valid` outputs and is the exit point toward the NIC/host.

## Interface
Parameters:
- REG_WIDTH, 32, width of every bundle word and of `o_tx_data`.
- DEPTH, 2, number of buffered bundle pairs; power of two, ≥2.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  capture strobe for the bundle pair (one-cycle pulse).
- i_reg_0_b … i_reg_8_b  in  REG_WIDTH each  buy message words 0–8.
- i_reg_0_s … i_reg_8_s  in  REG_WIDTH each  sell message words 0–8.
- i_tx_ready  in  1  downstream accepts a beat.
- o_tx_data  out  REG_WIDTH  current beat word.
- o_tx_valid  out  1  beat present.
- o_tx_sof  out  1  beat is word 0 of a message.
- o_tx_eof  out  1  beat is the last word of a message.
- o_tx_side  out  1  0 = buy message, 1 = sell message.
- o_full  out  1  DEPTH pairs buffered.
- o_drop_count  out  16  bundle pairs rejected while full; saturates at 0xFFFF.

## Operation
- Storage: DEPTH slots × 18 words. Write/read pointers of log2(DEPTH) bits wrap modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits.
- Capture: on `i_valid` with occupancy < DEPTH, all 18 words are written to the slot at the write pointer; the write pointer and occupancy advance.
- Overflow: `i_valid` with occupancy == DEPTH (registered value, before the edge) drops the pair and increments `o_drop_count`. This holds even if a pop completes in the same cycle.
- Transmit FSM:
  - IDLE: leave when occupancy > 0; go to SEND_BUY with word index 0.
  - SEND_BUY: emits buy words 0..LAST. When the LAST beat is accepted, go to SEND_SELL.
  - SEND_SELL: emits sell words 0..LAST. When the LAST beat is accepted, pop the slot, advance the read pointer, and decrement occupancy. Then go to SEND_BUY if another slot remains (no idle bubble), else IDLE.
- LAST = 8 (see Configuration).
- Handshake:
  - A beat transfers when `o_tx_valid && i_tx_ready`; the word index increments only on a transfer.
  - While `o_tx_valid && !i_tx_ready`, `o_tx_data`, `o_tx_sof`, `o_tx_eof` and `o_tx_side` hold stable.
  - `o_tx_valid` never drops without a transfer.
- Sideband: `o_tx_sof` = (index == 0). `o_tx_eof` = (index == LAST). `o_tx_side` = (state == SEND_SELL).
- Simultaneous capture and pop: occupancy is unchanged and both pointers advance.
- Reset mid-operation: FSM returns to IDLE, the FIFO empties, and the partial message is abandoned with no eof.

## Timing
- Reset values: `o_tx_data` = 0, `o_tx_valid` = 0, `o_tx_sof` = 0, `o_tx_eof` = 0, `o_tx_side` = 0, `o_full` = 0, `o_drop_count` = 0. FSM resets to IDLE and pointers to 0.
- Latency: `i_valid` at cycle N with the FSM idle and the FIFO empty gives the first beat (`o_tx_valid` = 1, buy word 0) at cycle N+1.
- Throughput: one beat per cycle while `i_tx_ready` = 1. One pair takes 18 cycles (20 with checksum).
- Outputs are registered.
- `o_full` reflects post-edge occupancy.

## Configuration
- ORDER_TX_CHECKSUM_EN
  - Defined: each message gets an appended word 9 equal to the XOR of words 0–8 of that message. LAST = 9, `o_tx_eof` is on word 9, and a pair is 20 beats.
  - Undefined: LAST = 8, 18 beats per pair, no checksum logic.

## Test plan
- Single pair, ready held 1: buy word k = 0x100+k, sell word k = 0x200+k, `i_valid` at cycle 0. Required: beats on cycles 1–18 carry 0x100..0x108 then 0x200..0x208. sof on beats 0 and 9, eof on beats 8 and 17, side 0 then 1.
- Backpressure: same data with `i_tx_ready` alternating 1/0. Required: outputs stay frozen on stalled cycles, exactly 18 transfers in order, no duplicates.
- Overflow (DEPTH = 2): ready = 0 and three `i_valid` pulses. Required: `o_full` = 1 after the second pulse, `o_drop_count` = 1, and releasing ready yields exactly 36 beats from pairs 1 and 2.
- Back-to-back: a second pair is captured during beat 5 of the first. Required: sell word 8 of pair 1 is followed next cycle by buy word 0 of pair 2, with `o_tx_valid` continuously 1 for 36 cycles.
- Reset mid-message: assert `i_reset_n` = 0 after 5 beats. Required: all outputs 0 immediately, and no beats after reset is released until a new `i_valid`.
- Checksum build: buy words 1..9 values 0x1..0x9 (words 0–8). Required: beat 9 = 0x1, eof on beat 9, and 20 beats total per pair.
